arith_scheduler: RTL and testbench

ARITH_SCHEDULER -- requirements
Module: arith_scheduler

---
 rtl/arith_scheduler.sv | 136 +++++++++++++
 tb/tb_arith_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_scheduler.sv
// Two-requester round-robin add/multiply unit with a single registered response slot.
// Latency: response valid EXEC_LAT+1 cycles after grant; one op in flight at a time.
// Backpressure: result held in RESP until rsp_ready; no grants while busy.
module arith_scheduler #(
    parameter int EXEC_LAT = 2,
    parameter int OP_CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic                req0_op,
    input  logic                req1_op,
    input  logic [2:0]          req0_a,
    input  logic [2:0]          req0_b,
    input  logic [2:0]          req1_a,
    input  logic [2:0]          req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [5:0]          rsp_data,
    output logic                busy,
    output logic [OP_CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic       op;
        logic [2:0] a;
        logic [2:0] b;
        logic       id;
    } op_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_LAT - 1);

    state_t     state, state_nxt;
    logic       rr;
    logic [3:0] exec_cnt;
    op_t        cur_op;
    op_t        sel_op;
    logic       grant_id;
    logic       req_hs;
    logic       exec_done;
    logic       rsp_hs;
    logic [3:0] sum4;
    logic [5:0] result;

    // Round-robin only matters when both requesters compete.
    always_comb begin
        grant_id = rr;
        if (req_valid == 2'b01)
            grant_id = 1'b0;
        else if (req_valid == 2'b10)
            grant_id = 1'b1;
    end

    always_comb begin
        if (grant_id)
            sel_op = '{op: req1_op, a: req1_a, b: req1_b, id: 1'b1};
        else
            sel_op = '{op: req0_op, a: req0_a, b: req0_b, id: 1'b0};
    end

    always_comb begin
        sum4   = {1'b0, cur_op.a} + {1'b0, cur_op.b};
        result = cur_op.op ? {2'b00, sum4} : ({3'b000, cur_op.a} * {3'b000, cur_op.b});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        req_hs    = 1'b0;
        exec_done = 1'b0;
        rsp_hs    = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant_id] = 1'b1;
                    req_hs              = 1'b1;
                    state_nxt           = EXEC;
                end
            end
            EXEC: begin
                if (exec_cnt == EXEC_LAST) begin
                    exec_done = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= 1'b0;
            exec_cnt <= 4'd0;
            cur_op   <= '0;
            rsp_data <= 6'd0;
            rsp_id   <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (req_hs) begin
                cur_op   <= sel_op;
                rr       <= ~grant_id;
                exec_cnt <= 4'd0;
            end else if (state == EXEC && !exec_done) begin
                exec_cnt <= exec_cnt + 4'd1;
            end
            if (exec_done) begin
                rsp_data <= result;
                rsp_id   <= cur_op.id;
            end
            if (rsp_hs)
                done_cnt <= done_cnt + OP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_arith_scheduler.sv
// Scoreboard bench for arith_scheduler: directed requests push expected results,
// a negedge monitor pops and compares on each response handshake.
module tb_arith_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic       req0_op, req1_op;
    logic [2:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_ready;

    logic [1:0] req_ready;
    logic       rsp_valid, rsp_id, busy;
    logic [5:0] rsp_data;
    logic [7:0] done_cnt;

    logic [1:0] w2_req_ready;
    logic       w2_rsp_valid, w2_rsp_id, w2_busy;
    logic [5:0] w2_rsp_data;
    logic [1:0] w2_done_cnt;

    always #5 clk = ~clk;

    arith_scheduler #(.EXEC_LAT(2), .OP_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .done_cnt(done_cnt)
    );

    arith_scheduler #(.EXEC_LAT(2), .OP_CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w2_req_ready),
        .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_a(req1_a), .req1_b(req1_b), .rsp_valid(w2_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(w2_rsp_id), .rsp_data(w2_rsp_data), .busy(w2_busy), .done_cnt(w2_done_cnt)
    );

    typedef struct {
        logic       id;
        logic [5:0] data;
        int         gcyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: latency, hold-while-stalled, result and counter checks.
    logic       prev_vld = 1'b0, prev_rdy = 1'b0, prev_id = 1'b0;
    logic [5:0] prev_data = 6'd0;
    bit         cnt_pend = 1'b0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
            hs_cnt   = 0;
            cnt_pend = 1'b0;
        end else begin
            if (cnt_pend) begin
                chk("done_cnt", done_cnt, hs_cnt % 256);
                chk("done_cnt_w2", w2_done_cnt, hs_cnt % 4);
                cnt_pend = 1'b0;
            end
            if (busy) chk("req_ready_while_busy", req_ready, 0);
            if (rsp_valid) chk("busy_in_resp", busy, 1);
            if (rsp_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got id %0d data %0d, expected no response", rsp_id, rsp_data);
                end else begin
                    chk("rsp_latency", cyc - exp_q[0].gcyc, 3);
                end
            end
            if (rsp_valid && prev_vld && !prev_rdy) begin
                chk("hold_data", rsp_data, prev_data);
                chk("hold_id", rsp_id, prev_id);
            end
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", rsp_id, mon_e.id);
                chk("rsp_data", rsp_data, mon_e.data);
                hs_cnt++;
                cnt_pend = 1'b1;
            end
            prev_vld  = rsp_valid;
            prev_rdy  = rsp_ready;
            prev_id   = rsp_id;
            prev_data = rsp_data;
        end
    end

    task automatic issue(input bit r, input bit op, input logic [2:0] a, input logic [2:0] b,
                         input logic [5:0] expd);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (r) begin
            req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_op = op; req0_a = a; req0_b = b;
        end
        req_valid[r] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            chk("grant_onehot", req_ready, r ? 2 : 1);
            exp_q.push_back('{id: r, data: expd, gcyc: cyc});
        end else begin
            fail_now("grant_wait");
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n = 1'b0;
        req_valid = 2'b00;
        req0_op = 1'b0; req1_op = 1'b0;
        req0_a = 3'd0; req0_b = 3'd0; req1_a = 3'd0; req1_b = 3'd0;
        rsp_ready = 1'b1;

        // Reset values
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        // Both requesters held valid from the first cycle: grants alternate 0,1,0,1
        @(posedge clk); #1;
        req_valid = 2'b11;
        req0_op = 1'b1; req0_a = 3'd3; req0_b = 3'd4;
        req1_op = 1'b0; req1_a = 3'd2; req1_b = 3'd3;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                fail_now("rr_grant_wait");
            end else begin
                chk("rr_grant_order", req_ready, (g % 2) ? 2 : 1);
                if (req_ready[1])
                    exp_q.push_back('{id: 1'b1, data: 6'd6, gcyc: cyc});
                else
                    exp_q.push_back('{id: 1'b0, data: 6'd7, gcyc: cyc});
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();
        chk("done_cnt_after_4", done_cnt, 4);
        chk("done_cnt_w2_after_4", w2_done_cnt, 0);

        // Single-requester directed operations
        issue(1'b0, 1'b1, 3'd7, 3'd7, 6'd14);
        issue(1'b1, 1'b0, 3'd7, 3'd7, 6'd49);
        issue(1'b0, 1'b0, 3'd0, 3'd5, 6'd0);
        issue(1'b1, 1'b1, 3'd0, 3'd0, 6'd0);
        issue(1'b0, 1'b0, 3'd6, 3'd3, 6'd18);
        issue(1'b1, 1'b1, 3'd5, 3'd6, 6'd11);
        drain();

        // Stall the response for 10 cycles while requests and operands wiggle
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b1, 1'b0, 3'd7, 3'd5, 6'd35);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("stall_rsp_wait");
        @(posedge clk); #1;
        req_valid = 2'b11;
        req0_op = 1'b1; req0_a = 3'd1; req0_b = 3'd2;
        req1_op = 1'b1; req1_a = 3'd4; req1_b = 3'd4;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_data", rsp_data, 35);
            chk("stall_busy", busy, 1);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        drain();

        // Reset in the middle of EXEC aborts the operation
        @(posedge clk); #1;
        req0_op = 1'b1; req0_a = 3'd1; req0_b = 3'd1;
        req_valid = 2'b01;
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("abort_grant_wait");
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_done_cnt_w2", w2_done_cnt, 0);
        chk("abort_rsp_data", rsp_data, 0);
        chk("abort_req_ready", req_ready, 0);
        @(negedge clk); #2;
        rst_n = 1'b1;

        @(posedge clk); #1;
        req_valid = 2'b11;
        req0_op = 1'b1; req0_a = 3'd2; req0_b = 3'd3;
        req1_op = 1'b0; req1_a = 3'd3; req1_b = 3'd3;
        @(negedge clk);
        chk("grant_after_reset", req_ready, 1);
        if (req_ready == 2'b01)
            exp_q.push_back('{id: 1'b0, data: 6'd5, gcyc: cyc});
        @(posedge clk); #1;
        req_valid = 2'b00;
        drain();
        chk("done_cnt_after_reset_op", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
